// File: rtl/ir_pkg.sv
// Shared definitions for the IR/DRAM load sequencer: fetch states, diag
// function codes and the staging-word field map.
package ir_pkg;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_LDIR,
    FS_RDWAIT,
    FS_LDDR
  } fetch_state_t;

  localparam logic [2:0] DIAG_FUNC_AB     = 3'd0;
  localparam logic [2:0] DIAG_FUNC_PJ     = 3'd1;
  localparam logic [2:0] DIAG_FUNC_J710   = 3'd2;
  localparam logic [2:0] DIAG_FUNC_ADDR   = 3'd3;
  localparam logic [2:0] DIAG_FUNC_COMMIT = 3'd4;
  localparam logic [2:0] DIAG_FUNC_ENIO   = 3'd5;
  localparam logic [2:0] DIAG_FUNC_ENAC   = 3'd6;
  localparam logic [2:0] DIAG_FUNC_CLEAR  = 3'd7;

  // Staging word {A[2:0], B[2:0], P, J1..4, J7..10}; upper DRAM bits stay 0.
  localparam int unsigned STAGE_W      = 15;
  localparam int unsigned STG_A_LSB    = 12;
  localparam int unsigned STG_B_LSB    = 9;
  localparam int unsigned STG_P_BIT    = 8;
  localparam int unsigned STG_J14_LSB  = 4;
  localparam int unsigned STG_J710_LSB = 0;

endpackage

// File: rtl/ir_diag_stage.sv
// Diagnostic staging: decodes EBUS diag functions into the DRAM staging word,
// write address and enable latches, and raises commit/cancel requests.
module ir_diag_stage
  import ir_pkg::*;
#(
  parameter int unsigned DRAM_AW = 9
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               diag_strobe,
  input  logic [2:0]         diag_func,
  input  logic [0:35]        ebus,
  input  logic               pending,
  output logic [STAGE_W-1:0] stage_word,
  output logic [DRAM_AW-1:0] addr,
  output logic               en_io_jrst,
  output logic               en_ac,
  output logic               commit_req,
  output logic               cancel_req
);

  logic take;
  logic clear;
  logic unused_ebus;

  // While a commit is pending only the clear function is honoured.
  assign clear       = diag_strobe && (diag_func == DIAG_FUNC_CLEAR);
  assign take        = diag_strobe && !pending && (diag_func != DIAG_FUNC_CLEAR);
  assign commit_req  = take && (diag_func == DIAG_FUNC_COMMIT);
  assign cancel_req  = clear && pending;
  assign unused_ebus = ^ebus[6:35-DRAM_AW];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stage_word <= '0;
      addr       <= '0;
      en_io_jrst <= 1'b0;
      en_ac      <= 1'b0;
    end else if (clear) begin
      stage_word <= '0;
      en_io_jrst <= 1'b0;
      en_ac      <= 1'b0;
    end else if (take) begin
      case (diag_func)
        DIAG_FUNC_AB: begin
          stage_word[STG_A_LSB +: 3] <= ebus[0:2];
          stage_word[STG_B_LSB +: 3] <= ebus[3:5];
        end
        DIAG_FUNC_PJ: begin
          stage_word[STG_P_BIT]        <= ebus[0];
          stage_word[STG_J14_LSB +: 4] <= ebus[1:4];
        end
        DIAG_FUNC_J710: stage_word[STG_J710_LSB +: 4] <= ebus[0:3];
        DIAG_FUNC_ADDR: addr       <= ebus[36-DRAM_AW:35];
        DIAG_FUNC_ENIO: en_io_jrst <= ebus[0];
        DIAG_FUNC_ENAC: en_ac      <= ebus[0];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ir_load_ctl.sv
// IR/DRAM fetch sequencer and dram_mem port arbiter: issues loadIR ->
// read wait -> loadDRAM per fetch and slots diagnostic writes into idle cycles.
module ir_load_ctl
  import ir_pkg::*;
#(
  parameter int unsigned DRAM_AW = 9,
  parameter int unsigned DRAM_DW = 24,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               fetchReq,
  input  logic               mbXferIn,
  output logic               fetchAck,
  output logic               loadIR,
  output logic               mbXfer,
  output logic               loadDRAM,
  output logic               dramReady,
  input  logic               diagLoadFunc06X,
  input  logic [2:0]         diagFunc,
  input  logic [0:35]        EBUS,
  output logic [DRAM_AW-1:0] dramAddr,
  output logic [DRAM_DW-1:0] dramDin,
  output logic               dramWe,
  output logic               diagBusy,
  output logic               diagDone,
  output logic               enIO_JRST,
  output logic               enAC
);

  fetch_state_t       state, state_nx;
  logic [1:0]         lat_cnt;
  logic               pending;
  logic               accept;
  logic               grant;
  logic               commit_req;
  logic               cancel_req;
  logic [STAGE_W-1:0] stage_word;

  ir_diag_stage #(.DRAM_AW(DRAM_AW)) u_stage (
    .clk         (clk),
    .resetN      (resetN),
    .diag_strobe (diagLoadFunc06X),
    .diag_func   (diagFunc),
    .ebus        (EBUS),
    .pending     (pending),
    .stage_word  (stage_word),
    .addr        (dramAddr),
    .en_io_jrst  (enIO_JRST),
    .en_ac       (enAC),
    .commit_req  (commit_req),
    .cancel_req  (cancel_req)
  );

  // Acceptance is combinational on fetchReq, so it is gated by reset to keep
  // fetchAck low while the block is held in reset.
  assign accept = resetN && (state == FS_IDLE) && fetchReq;
  assign grant  = pending && (state == FS_IDLE) && !fetchReq && !cancel_req;

  always_comb begin
    state_nx = state;
    fetchAck = accept;
    loadIR   = 1'b0;
    loadDRAM = 1'b0;
    case (state)
      FS_IDLE:   if (accept) state_nx = FS_LDIR;
      FS_LDIR: begin
        loadIR   = 1'b1;
        state_nx = FS_RDWAIT;
      end
      FS_RDWAIT: if (lat_cnt == 2'd0) state_nx = FS_LDDR;
      FS_LDDR: begin
        loadDRAM = 1'b1;
        state_nx = FS_IDLE;
      end
      default:   state_nx = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= FS_IDLE;
      lat_cnt   <= '0;
      mbXfer    <= 1'b0;
      dramReady <= 1'b0;
      pending   <= 1'b0;
      diagDone  <= 1'b0;
    end else begin
      state     <= state_nx;
      dramReady <= (state == FS_LDDR);
      diagDone  <= grant;
      if (accept) mbXfer <= mbXferIn;
      if (state == FS_LDIR) lat_cnt <= 2'(RD_LAT - 1);
      else if (state == FS_RDWAIT && lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
      if (grant || cancel_req) pending <= 1'b0;
      else if (commit_req)     pending <= 1'b1;
    end
  end

  assign dramWe   = grant;
  assign dramDin  = DRAM_DW'(stage_word);
  assign diagBusy = pending;

endmodule

// File: tb/tb_ir_load_ctl.sv
// Bench for ir_load_ctl: two instances (RD_LAT 1 and 3) share stimulus and are
// compared every cycle against a time-based behavioural model.
module tb_ir_load_ctl;

  logic        clk = 1'b0;
  logic        resetN;
  logic        fetchReq;
  logic        mbXferIn;
  logic        diagLoadFunc06X;
  logic [2:0]  diagFunc;
  logic [0:35] EBUS;

  logic       d1_fetchAck, d1_loadIR, d1_mbXfer, d1_loadDRAM, d1_dramReady;
  logic       d1_dramWe, d1_diagBusy, d1_diagDone, d1_enIO_JRST, d1_enAC;
  logic [8:0] d1_dramAddr;
  logic [23:0] d1_dramDin;
  logic       d3_fetchAck, d3_loadIR, d3_mbXfer, d3_loadDRAM, d3_dramReady;
  logic       d3_dramWe, d3_diagBusy, d3_diagDone, d3_enIO_JRST, d3_enAC;
  logic [8:0] d3_dramAddr;
  logic [23:0] d3_dramDin;

  always #5 clk = ~clk;

  ir_load_ctl #(.DRAM_AW(9), .DRAM_DW(24), .RD_LAT(1)) u_dut1 (
    .clk(clk), .resetN(resetN), .fetchReq(fetchReq), .mbXferIn(mbXferIn),
    .fetchAck(d1_fetchAck), .loadIR(d1_loadIR), .mbXfer(d1_mbXfer),
    .loadDRAM(d1_loadDRAM), .dramReady(d1_dramReady),
    .diagLoadFunc06X(diagLoadFunc06X), .diagFunc(diagFunc), .EBUS(EBUS),
    .dramAddr(d1_dramAddr), .dramDin(d1_dramDin), .dramWe(d1_dramWe),
    .diagBusy(d1_diagBusy), .diagDone(d1_diagDone),
    .enIO_JRST(d1_enIO_JRST), .enAC(d1_enAC)
  );

  ir_load_ctl #(.DRAM_AW(9), .DRAM_DW(24), .RD_LAT(3)) u_dut3 (
    .clk(clk), .resetN(resetN), .fetchReq(fetchReq), .mbXferIn(mbXferIn),
    .fetchAck(d3_fetchAck), .loadIR(d3_loadIR), .mbXfer(d3_mbXfer),
    .loadDRAM(d3_loadDRAM), .dramReady(d3_dramReady),
    .diagLoadFunc06X(diagLoadFunc06X), .diagFunc(diagFunc), .EBUS(EBUS),
    .dramAddr(d3_dramAddr), .dramDin(d3_dramDin), .dramWe(d3_dramWe),
    .diagBusy(d3_diagBusy), .diagDone(d3_diagDone),
    .enIO_JRST(d3_enIO_JRST), .enAC(d3_enAC)
  );

  // obs bit map: 9 fetchAck 8 loadIR 7 mbXfer 6 loadDRAM 5 dramReady
  //              4 dramWe 3 diagBusy 2 diagDone 1 enIO_JRST 0 enAC
  logic [9:0]  obs      [2];
  logic [8:0]  obs_addr [2];
  logic [23:0] obs_din  [2];
  assign obs[0] = {d1_fetchAck, d1_loadIR, d1_mbXfer, d1_loadDRAM, d1_dramReady,
                   d1_dramWe, d1_diagBusy, d1_diagDone, d1_enIO_JRST, d1_enAC};
  assign obs[1] = {d3_fetchAck, d3_loadIR, d3_mbXfer, d3_loadDRAM, d3_dramReady,
                   d3_dramWe, d3_diagBusy, d3_diagDone, d3_enIO_JRST, d3_enAC};
  assign obs_addr[0] = d1_dramAddr;
  assign obs_addr[1] = d3_dramAddr;
  assign obs_din[0]  = d1_dramDin;
  assign obs_din[1]  = d3_dramDin;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model: a fetch accepted at cycle t occupies t+1 .. t+2+L; loadIR at t+1,
  // loadDRAM at t+2+L, dramReady at t+3+L (block is idle again then).
  int         cyc = 0;
  int         m_acc   [2];
  bit         m_accv  [2];
  bit         m_mbx   [2];
  bit         m_pend  [2];
  bit         m_done  [2];
  logic [2:0] m_a     [2];
  logic [2:0] m_b     [2];
  bit         m_p     [2];
  logic [3:0] m_j14   [2];
  logic [3:0] m_j710  [2];
  logic [8:0] m_addr  [2];
  bit         m_enio  [2];
  bit         m_enac  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear(input int k);
    m_accv[k] = 0; m_mbx[k] = 0; m_pend[k] = 0; m_done[k] = 0;
    m_a[k] = '0; m_b[k] = '0; m_p[k] = 0; m_j14[k] = '0; m_j710[k] = '0;
    m_addr[k] = '0; m_enio[k] = 0; m_enac[k] = 0;
  endtask

  task automatic check_and_step();
    for (int k = 0; k < 2; k++) begin
      int    lat;
      int    d;
      bit    busy, e_ack, e_ir, e_dr, e_rdy, e_we, old_p;
      string nm;
      lat = (k == 0) ? 1 : 3;
      nm  = (k == 0) ? "L1" : "L3";
      if (!resetN) begin
        chk({nm, " outputs in reset"}, 32'(obs[k]), 32'd0);
        chk({nm, " dramAddr in reset"}, 32'(obs_addr[k]), 32'd0);
        chk({nm, " dramDin in reset"}, 32'(obs_din[k]), 32'd0);
        model_clear(k);
      end else begin
        d     = cyc - m_acc[k];
        busy  = m_accv[k] && d >= 1 && d <= 2 + lat;
        e_ir  = m_accv[k] && d == 1;
        e_dr  = m_accv[k] && d == 2 + lat;
        e_rdy = m_accv[k] && d == 3 + lat;
        e_ack = !busy && fetchReq;
        e_we  = m_pend[k] && !busy && !fetchReq &&
                !(diagLoadFunc06X && diagFunc == 3'd7);
        chk({nm, " fetchAck"},  32'(obs[k][9]), 32'(e_ack));
        chk({nm, " loadIR"},    32'(obs[k][8]), 32'(e_ir));
        chk({nm, " mbXfer"},    32'(obs[k][7]), 32'(m_mbx[k]));
        chk({nm, " loadDRAM"},  32'(obs[k][6]), 32'(e_dr));
        chk({nm, " dramReady"}, 32'(obs[k][5]), 32'(e_rdy));
        chk({nm, " dramWe"},    32'(obs[k][4]), 32'(e_we));
        chk({nm, " diagBusy"},  32'(obs[k][3]), 32'(m_pend[k]));
        chk({nm, " diagDone"},  32'(obs[k][2]), 32'(m_done[k]));
        chk({nm, " enIO_JRST"}, 32'(obs[k][1]), 32'(m_enio[k]));
        chk({nm, " enAC"},      32'(obs[k][0]), 32'(m_enac[k]));
        chk({nm, " dramAddr"},  32'(obs_addr[k]), 32'(m_addr[k]));
        chk({nm, " dramDin"},   32'(obs_din[k]),
            32'({m_a[k], m_b[k], m_p[k], m_j14[k], m_j710[k]}));
        if (e_ack) begin
          m_acc[k]  = cyc;
          m_accv[k] = 1;
          m_mbx[k]  = mbXferIn;
        end
        m_done[k] = e_we;
        old_p     = m_pend[k];
        if (e_we) m_pend[k] = 0;
        if (diagLoadFunc06X) begin
          if (diagFunc == 3'd7) begin
            m_a[k] = '0; m_b[k] = '0; m_p[k] = 0; m_j14[k] = '0; m_j710[k] = '0;
            m_enio[k] = 0; m_enac[k] = 0; m_pend[k] = 0;
          end else if (!old_p) begin
            case (diagFunc)
              3'd0: begin m_a[k] = EBUS[0:2]; m_b[k] = EBUS[3:5]; end
              3'd1: begin m_p[k] = EBUS[0]; m_j14[k] = EBUS[1:4]; end
              3'd2: m_j710[k] = EBUS[0:3];
              3'd3: m_addr[k] = EBUS[27:35];
              3'd4: m_pend[k] = 1;
              3'd5: m_enio[k] = EBUS[0];
              3'd6: m_enac[k] = EBUS[0];
              default: ;
            endcase
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_and_step();
    @(posedge clk);
    #1;
  endtask

  task automatic diag(input logic [2:0] f, input logic [0:35] e);
    diagLoadFunc06X = 1'b1;
    diagFunc        = f;
    EBUS            = e;
    cycle();
    diagLoadFunc06X = 1'b0;
    EBUS            = '0;
  endtask

  initial begin
    logic [0:35] e;
    for (int k = 0; k < 2; k++) begin
      model_clear(k);
      m_acc[k] = 0;
    end
    resetN = 1'b0; fetchReq = 1'b0; mbXferIn = 1'b0;
    diagLoadFunc06X = 1'b0; diagFunc = '0; EBUS = '0;
    repeat (3) cycle();
    resetN = 1'b1;
    repeat (2) cycle();

    // Single fetch, mbXferIn=1
    fetchReq = 1'b1; mbXferIn = 1'b1;
    cycle();
    fetchReq = 1'b0; mbXferIn = 1'b0;
    repeat (7) cycle();

    // Reset asserted while in LDIR
    fetchReq = 1'b1;
    cycle();
    fetchReq = 1'b0;
    resetN   = 1'b0;
    #1;
    chk("L1 async reset in LDIR", 32'(obs[0]), 32'd0);
    chk("L3 async reset in LDIR", 32'(obs[1]), 32'd0);
    cycle();
    resetN = 1'b1;
    repeat (8) cycle();

    // Diagnostic write with no fetch
    e = '0; e[0:5] = 6'o57;    diag(3'd0, e);
    e = '0; e[0:4] = 5'b10110; diag(3'd1, e);
    e = '0; e[0:3] = 4'hA;     diag(3'd2, e);
    e = '0; e[27:35] = 9'o254; diag(3'd3, e);
    diag(3'd4, '0);
    #1;
    chk("L1 diag write we",   32'(d1_dramWe),   32'd1);
    chk("L1 diag write addr", 32'(d1_dramAddr), 32'o254);
    chk("L1 diag write din",  32'(d1_dramDin),  32'h005F6A);
    chk("L3 diag write din",  32'(d3_dramDin),  32'h005F6A);
    repeat (3) cycle();

    // Commit collides with fetchReq in IDLE
    e = '0; e[27:35] = 9'o123; diag(3'd3, e);
    fetchReq = 1'b1; diagLoadFunc06X = 1'b1; diagFunc = 3'd4;
    cycle();
    fetchReq = 1'b0; diagLoadFunc06X = 1'b0;
    repeat (9) cycle();

    // Cancel a deferred commit with func 7
    fetchReq = 1'b1; diagLoadFunc06X = 1'b1; diagFunc = 3'd4;
    cycle();
    fetchReq = 1'b0; diagLoadFunc06X = 1'b0;
    diag(3'd7, '0);
    repeat (8) cycle();
    chk("L1 staging cleared by cancel", 32'(d1_dramDin), 32'd0);

    // func5 ignored while a commit is pending
    e = '0; e[0:5] = 6'o72; diag(3'd0, e);
    fetchReq = 1'b1; diagLoadFunc06X = 1'b1; diagFunc = 3'd4;
    cycle();
    fetchReq = 1'b0; diagLoadFunc06X = 1'b0;
    e = '0; e[0] = 1'b1; diag(3'd5, e);
    repeat (8) cycle();
    chk("L1 enIO ignored while pending", 32'(d1_enIO_JRST), 32'd0);

    // Enables set and cleared
    e = '0; e[0] = 1'b1;
    diag(3'd5, e);
    diag(3'd6, e);
    chk("L1 enables set", 32'({d1_enIO_JRST, d1_enAC}), 32'd3);
    diag(3'd7, '0);
    chk("L1 enables cleared", 32'({d1_enIO_JRST, d1_enAC}), 32'd0);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      resetN          = ($urandom_range(99) != 0);
      fetchReq        = ($urandom_range(2) == 0);
      mbXferIn        = 1'($urandom);
      diagLoadFunc06X = ($urandom_range(2) == 0);
      diagFunc        = 3'($urandom);
      EBUS            = {$urandom, 4'($urandom)};
      cycle();
    end
    resetN = 1'b1; fetchReq = 1'b0; diagLoadFunc06X = 1'b0;
    repeat (6) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
